sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
- Physical memory controller: the responder end of the MMU's dev_mem_* interface.
- Turns word-aligned single-cycle read and write requests into timed cycles on one external asynchronous 32-bit SRAM.
- Sequences multi-cycle accesses and drives mem_busy so the MMU stalls until each access finishes.
- Holds a one-entry read buffer so repeated reads of the same word complete with zero wait.

Parameters:
- ADDR_WIDTH, 20: SRAM word-address width. Byte addresses map as mem_addr[ADDR_WIDTH+1:2].
- READ_WAIT, 2: cycles from address drive to data capture on a miss. 0 selects a combinational pass-through read path.
- WE_CYCLES, 2: cycles that sram_we_n is held low per write, minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_addr  in  32  byte address from the MMU. Bits [1:0] are ignored.
- mem_data_in  in  32  write data from the MMU.
- mem_data_out  out  32  read data to the MMU.
- mem_is_write  in  1  write strobe, high for exactly one cycle per write.
- mem_busy  out  1  request not yet complete.
- sram_addr  out  ADDR_WIDTH  SRAM word address.
- sram_data_o  out  32  data driven toward the SRAM.
- sram_data_i  in  32  data sampled from the SRAM.
- sram_data_oe  out  1  tri-state enable for sram_data_o.
- sram_ce_n  out  1  SRAM chip enable, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.
- sram_we_n  out  1  SRAM write enable, active-low.

Behaviour:
- Reset (rst low, takes effect immediately, also mid-access):
  - state=IDLE, rd_valid=0, counter=0.
  - sram_ce_n=sram_oe_n=sram_we_n=1, sram_data_oe=0, mem_busy=0, mem_data_out=0.
  - An interrupted write may leave the SRAM word undefined.
- in_range = (mem_addr[31:ADDR_WIDTH+2] == 0). word = mem_addr[ADDR_WIDTH+1:2].
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE, read request (mem_is_write=0):
  - Out of range: mem_data_out=0, mem_busy=0, SRAM untouched.
  - READ_WAIT=0: sram_addr=word, ce_n=oe_n=0, mem_data_out=sram_data_i combinationally, mem_busy=0.
  - Hit (rd_valid and rd_tag==word): mem_data_out=rd_data, mem_busy=0, no SRAM access.
  - Miss: mem_busy=1 combinationally in the same cycle. Drive sram_addr=word with ce_n=oe_n=0. Latch the word into rd_tag, set counter=READ_WAIT, go to RD_WAIT.
- RD_WAIT:
  - Drive the latched address with ce_n=oe_n=0; mem_busy=1; decrement counter.
  - When counter reaches 1: capture sram_data_i into rd_data, set rd_valid=1, go to IDLE.
  - The next cycle hits, so data is valid the cycle after mem_busy drops.
  - A changed mem_addr during RD_WAIT is ignored. The new address misses after return to IDLE.
- IDLE, mem_is_write=1:
  - Out of range: write dropped, mem_busy=0.
  - Otherwise mem_busy=1 combinationally. Latch word and mem_data_in at the posedge, go to WR_SETUP.
  - mem_is_write has priority over a read in the same cycle.
- Write sequence:
  - WR_SETUP: 1 cycle. Latched address and data driven, sram_data_oe=1, ce_n=0, we_n=1, oe_n=1.
  - WR_PULSE: WE_CYCLES cycles with we_n=0.
  - WR_HOLD: 1 cycle, we_n=1, data still driven. Then go to IDLE with sram_data_oe=0.
  - mem_busy=1 in all three states. Total busy = WE_CYCLES+2 cycles after the strobe cycle.
  - If the written word equals rd_tag with rd_valid set, rd_data is updated with the write data at WR_HOLD.
- mem_is_write asserted outside IDLE is a protocol violation: ignored, with a simulation warning.
- sram_oe_n=0 and sram_data_oe=1 are never both true in any cycle.
- Counter width: clog2(max(READ_WAIT,WE_CYCLES)+1).

Test Plan:
- Reset low mid-WR_PULSE, then release -> we_n=1 and data_oe=0 immediately; state IDLE; rd_valid=0; mem_busy=0.
- Read 0x00000010 with SRAM word 4 = 0xDEADBEEF, READ_WAIT=2 -> mem_busy high 2 cycles, sram_addr=4, then mem_data_out=0xDEADBEEF with busy=0. A repeat read of 0x10 gives busy=0 in the same cycle.
- Write 0x12345678 to 0x20 -> busy for 4 cycles; we_n low exactly 2 cycles with sram_addr=8 and data stable one cycle before and after the pulse. A following read of 0x20 returns 0x12345678.
- Read 0x20 (fills buffer), write 0xCAFEF00D to 0x20, read 0x20 -> buffer hit, returns 0xCAFEF00D with no SRAM read.
- Out-of-range address 0x00400000 (ADDR_WIDTH=20): read -> mem_data_out=0, busy=0; write -> busy=0, ce_n stays 1.
- READ_WAIT=0 build: mem_addr steps 0x0, 0x4, 0x8 on consecutive cycles -> mem_data_out follows sram_data_i each cycle with busy=0 throughout.

Source files
------------

// File: rtl/sram_ctrl.sv
// Responder for the MMU dev_mem_* port: sequences timed read/write cycles on one
// asynchronous 32-bit SRAM and keeps a one-word read buffer for zero-wait repeat reads.
module sram_ctrl #(
    parameter int ADDR_WIDTH = 20,
    parameter int READ_WAIT  = 2,
    parameter int WE_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_data_in,
    output logic [31:0]           mem_data_out,
    input  logic                  mem_is_write,
    output logic                  mem_busy,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_data_o,
    input  logic [31:0]           sram_data_i,
    output logic                  sram_data_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int MAX_WAIT = (READ_WAIT > WE_CYCLES) ? READ_WAIT : WE_CYCLES;
    localparam int CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         counter, cnt_nxt;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_tag;
    logic [31:0]           rd_data;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word;
    logic                  rd_start, rd_capture, wr_start, buf_update;
    logic                  unused_low_bits;

    assign in_range        = (mem_addr[31:ADDR_WIDTH+2] == '0);
    assign word            = mem_addr[ADDR_WIDTH+1:2];
    assign unused_low_bits = ^mem_addr[1:0];
    assign sram_data_o     = wdata_q;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = counter;
        mem_busy     = 1'b0;
        mem_data_out = 32'h0;
        sram_addr    = addr_q;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_data_oe = 1'b0;
        rd_start     = 1'b0;
        rd_capture   = 1'b0;
        wr_start     = 1'b0;
        buf_update   = 1'b0;

        case (state)
            IDLE: begin
                if (mem_is_write) begin
                    if (in_range) begin
                        mem_busy  = 1'b1;
                        wr_start  = 1'b1;
                        state_nxt = WR_SETUP;
                    end
                end else if (in_range) begin
                    if (READ_WAIT == 0) begin
                        sram_addr    = word;
                        sram_ce_n    = 1'b0;
                        sram_oe_n    = 1'b0;
                        mem_data_out = sram_data_i;
                    end else if (rd_valid && rd_tag == word) begin
                        mem_data_out = rd_data;
                    end else begin
                        mem_busy  = 1'b1;
                        sram_addr = word;
                        sram_ce_n = 1'b0;
                        sram_oe_n = 1'b0;
                        rd_start  = 1'b1;
                        // A single wait cycle completes at the end of this very cycle.
                        if (READ_WAIT == 1) begin
                            rd_capture = 1'b1;
                        end else begin
                            cnt_nxt   = CW'(READ_WAIT);
                            state_nxt = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                mem_busy  = 1'b1;
                sram_addr = rd_tag;
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                cnt_nxt   = counter - CNT_ONE;
                if (cnt_nxt == CNT_ONE) begin
                    rd_capture = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end
            end
            WR_SETUP: begin
                mem_busy     = 1'b1;
                sram_ce_n    = 1'b0;
                sram_data_oe = 1'b1;
                cnt_nxt      = CW'(WE_CYCLES);
                state_nxt    = WR_PULSE;
            end
            WR_PULSE: begin
                mem_busy     = 1'b1;
                sram_ce_n    = 1'b0;
                sram_we_n    = 1'b0;
                sram_data_oe = 1'b1;
                cnt_nxt      = counter - CNT_ONE;
                if (counter == CNT_ONE) begin
                    cnt_nxt   = '0;
                    state_nxt = WR_HOLD;
                end
            end
            WR_HOLD: begin
                mem_busy     = 1'b1;
                sram_ce_n    = 1'b0;
                sram_data_oe = 1'b1;
                buf_update   = rd_valid && (rd_tag == addr_q);
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Reset must quiet the bus immediately, even mid-access.
        if (!rst) begin
            mem_busy     = 1'b0;
            mem_data_out = 32'h0;
            sram_ce_n    = 1'b1;
            sram_oe_n    = 1'b1;
            sram_we_n    = 1'b1;
            sram_data_oe = 1'b0;
            rd_start     = 1'b0;
            rd_capture   = 1'b0;
            wr_start     = 1'b0;
            buf_update   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            counter  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            counter <= cnt_nxt;
            if (rd_capture)
                rd_valid <= 1'b1;
            else if (rd_start)
                rd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_start)
            rd_tag <= word;
        if (rd_capture)
            rd_data <= sram_data_i;
        else if (buf_update)
            rd_data <= wdata_q;
        if (wr_start) begin
            addr_q  <= word;
            wdata_q <= mem_data_in;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(mem_is_write && state != IDLE))
        else $warning("sram_ctrl: mem_is_write while an access is in progress was ignored");

    assert property (@(posedge clk) !(!sram_oe_n && sram_data_oe))
        else $error("sram_ctrl: SRAM output enable and data drive active together");

endmodule
